// File: rtl/seq_mult_pkg.sv
// Shared encodings for the 8x8 sequential multiplier: FSM states, operand
// nibble selects, shifter selects and the pass count.
package seq_mult_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'b000,
        LSB       = 3'b001,
        MID       = 3'b010,
        MSB       = 3'b011,
        CALC_DONE = 3'b100,
        ERR       = 3'b101
    } state_t;

    localparam logic [1:0] SEL_LL = 2'b00;
    localparam logic [1:0] SEL_LH = 2'b01;
    localparam logic [1:0] SEL_HL = 2'b10;
    localparam logic [1:0] SEL_HH = 2'b11;

    localparam logic [1:0] SH_0 = 2'b00;
    localparam logic [1:0] SH_4 = 2'b01;
    localparam logic [1:0] SH_8 = 2'b10;

    localparam int NUM_PASSES = 4;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the 8x8 sequential multiplier: sequences four 4x4 partial
// products into the 16-bit product register and owns the 2-bit pass counter.
module seq_mult_ctrl
    import seq_mult_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [1:0] input_sel,
    output logic [1:0] shift_sel,
    output logic       clk_ena,
    output logic       sclr_n,
    output logic       done,
    output logic [2:0] state_out,
    output logic [1:0] count
);

    // MID is entered at count 1 and hands over to MSB once the count reaches this value.
    localparam logic [1:0] LAST_MID_COUNT = 2'(NUM_PASSES - 2);

    state_t     state_reg;
    state_t     state_next;
    logic [1:0] count_reg;
    logic [1:0] count_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            count_reg <= 2'd0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
        end
    end

    // Any start seen while accumulating suppresses that pass and parks in ERR.
    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        input_sel  = SEL_LL;
        shift_sel  = SH_0;
        clk_ena    = 1'b0;
        sclr_n     = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = LSB;
                    count_next = 2'd0;
                    clk_ena    = 1'b1;
                    sclr_n     = 1'b0;
                end
            end
            LSB: begin
                count_next = count_reg + 2'd1;
                if (start) begin
                    state_next = ERR;
                end else begin
                    state_next = MID;
                    clk_ena    = 1'b1;
                end
            end
            MID: begin
                count_next = count_reg + 2'd1;
                input_sel  = (count_reg == 2'd1) ? SEL_LH : SEL_HL;
                shift_sel  = SH_4;
                if (start) begin
                    state_next = ERR;
                end else begin
                    clk_ena    = 1'b1;
                    state_next = (count_reg == LAST_MID_COUNT) ? MSB : MID;
                end
            end
            MSB: begin
                count_next = count_reg + 2'd1;
                input_sel  = SEL_HH;
                shift_sel  = SH_8;
                if (start) begin
                    state_next = ERR;
                end else begin
                    state_next = CALC_DONE;
                    clk_ena    = 1'b1;
                end
            end
            CALC_DONE: begin
                done       = 1'b1;
                state_next = start ? ERR : IDLE;
            end
            ERR: begin
                if (start) begin
                    state_next = LSB;
                    count_next = 2'd0;
                    clk_ena    = 1'b1;
                    sclr_n     = 1'b0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign state_out = state_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed bench for seq_mult_ctrl with a small behavioural datapath
// (4x4 multiply, shifter, adder, 16-bit register) wrapped around it.
module tb_seq_mult_ctrl;
    import seq_mult_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [1:0] input_sel;
    logic [1:0] shift_sel;
    logic       clk_ena;
    logic       sclr_n;
    logic       done;
    logic [2:0] state_out;
    logic [1:0] count;

    logic [7:0]  a_op;
    logic [7:0]  b_op;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [7:0]  pp;
    logic [15:0] shifted;
    logic [15:0] prod;

    int n_checks;
    int n_fail;

    seq_mult_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .input_sel (input_sel),
        .shift_sel (shift_sel),
        .clk_ena   (clk_ena),
        .sclr_n    (sclr_n),
        .done      (done),
        .state_out (state_out),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        a_nib = input_sel[1] ? a_op[7:4] : a_op[3:0];
        b_nib = input_sel[0] ? b_op[7:4] : b_op[3:0];
        pp    = a_nib * b_nib;
        case (shift_sel)
            2'b01:   shifted = {4'd0, pp, 4'd0};
            2'b10:   shifted = {pp, 8'd0};
            default: shifted = {8'd0, pp};
        endcase
    end

    always_ff @(posedge clk) begin
        if (clk_ena) prod <= sclr_n ? (prod + shifted) : 16'd0;
    end

    // {state_out, input_sel, shift_sel, clk_ena, sclr_n, done, count}
    localparam logic [11:0] NOM_EXP [7] = '{
        12'b000_00_00_1_0_0_00,
        12'b001_00_00_1_1_0_00,
        12'b010_01_01_1_1_0_01,
        12'b010_10_01_1_1_0_10,
        12'b011_11_10_1_1_0_11,
        12'b100_00_00_0_0_1_00,
        12'b000_00_00_0_1_0_00
    };
    localparam logic [11:0] NOM_MASK [7] = '{
        12'b111_00_00_1_1_1_11,
        12'b111_11_11_1_1_1_11,
        12'b111_11_11_1_1_1_11,
        12'b111_11_11_1_1_1_11,
        12'b111_11_11_1_1_1_11,
        12'b111_00_00_1_0_1_11,
        12'b111_00_00_1_1_1_11
    };

    // Pulse start for one cycle; returns at the negedge opening the LSB cycle.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Cycles from the current one until done is seen, or -1 past the budget.
    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (done) begin
                cyc = i;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        start   = 1'b0;
        a_op    = 8'd0;
        b_op    = 8'd0;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({state_out, count, clk_ena, sclr_n, done, input_sel, shift_sel} !== 11'b000_00_0_1_0_00_00) begin
            n_fail++;
            $display("FAIL reset_pre_clock: got %b need %b",
                     {state_out, count, clk_ena, sclr_n, done, input_sel, shift_sel}, 11'b000_00_0_1_0_00_00);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (state_out !== 3'b000 || clk_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: state %b ena %b need 000 0", state_out, clk_ena);
        end
    endtask

    task automatic test_nominal();
        logic [11:0] obs;
        int cyc;
        a_op = 8'hFF;
        b_op = 8'hFF;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            start = (c == 0);
            #1;
            obs = {state_out, input_sel, shift_sel, clk_ena, sclr_n, done, count};
            n_checks++;
            if ((obs & NOM_MASK[c]) !== (NOM_EXP[c] & NOM_MASK[c])) begin
                n_fail++;
                $display("FAIL nominal_cycle%0d: got %b need %b (mask %b)", c, obs, NOM_EXP[c], NOM_MASK[c]);
            end
            if (c == 5) begin
                n_checks++;
                if (prod !== 16'hFE01) begin
                    n_fail++;
                    $display("FAIL nominal_product_ff: got %h need fe01", prod);
                end
            end
        end
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (prod !== 16'hFE01 || state_out !== 3'b000) begin
                n_fail++;
                $display("FAIL idle_hold%0d: prod %h state %b need fe01 000", i, prod, state_out);
            end
        end
        a_op = 8'h12;
        b_op = 8'h34;
        pulse_start();
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || prod !== 16'h03A8) begin
            n_fail++;
            $display("FAIL nominal_product_1234: cycles %0d prod %h need 4 03a8", cyc, prod);
        end
    endtask

    task automatic test_err_lsb();
        int cyc;
        a_op = 8'h12;
        b_op = 8'h34;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (state_out !== 3'b001 || clk_ena !== 1'b0 || sclr_n !== 1'b1) begin
            n_fail++;
            $display("FAIL err_lsb_cycle: state %b ena %b sclr %b need 001 0 1", state_out, clk_ena, sclr_n);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (state_out !== 3'b101 || clk_ena !== 1'b0 || done !== 1'b0 || prod !== 16'h0000) begin
            n_fail++;
            $display("FAIL err_enter: state %b ena %b done %b prod %h need 101 0 0 0000",
                     state_out, clk_ena, done, prod);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (state_out !== 3'b101 || prod !== 16'h0000) begin
            n_fail++;
            $display("FAIL err_hold: state %b prod %h need 101 0000", state_out, prod);
        end
        @(negedge clk);
        start = 1'b1;
        #1;
        n_checks++;
        if (state_out !== 3'b101 || clk_ena !== 1'b1 || sclr_n !== 1'b0) begin
            n_fail++;
            $display("FAIL err_restart: state %b ena %b sclr %b need 101 1 0", state_out, clk_ena, sclr_n);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (state_out !== 3'b001 || count !== 2'b00) begin
            n_fail++;
            $display("FAIL err_restart_lsb: state %b count %b need 001 00", state_out, count);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || prod !== 16'h03A8) begin
            n_fail++;
            $display("FAIL err_restart_product: cycles %0d prod %h need 4 03a8", cyc, prod);
        end
    endtask

    task automatic test_err_done();
        int cyc;
        a_op = 8'h0F;
        b_op = 8'hF0;
        pulse_start();
        wait_done(cyc);
        start = 1'b1;
        n_checks++;
        if (cyc !== 4 || prod !== 16'h0E10 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL done_product_0ff0: cycles %0d prod %h done %b need 4 0e10 1", cyc, prod, done);
        end
        @(negedge clk);
        start = 1'b0;
        #1;
        n_checks++;
        if (state_out !== 3'b101 || done !== 1'b0 || clk_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL done_to_err: state %b done %b ena %b need 101 0 0", state_out, done, clk_ena);
        end
        a_op = 8'h80;
        b_op = 8'h02;
        pulse_start();
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || prod !== 16'h0100) begin
            n_fail++;
            $display("FAIL err_recover_product: cycles %0d prod %h need 4 0100", cyc, prod);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        a_op = 8'hFF;
        b_op = 8'hFF;
        pulse_start();
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || prod !== 16'hFE01) begin
            n_fail++;
            $display("FAIL b2b_first: cycles %0d prod %h need 4 fe01", cyc, prod);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (state_out !== 3'b000) begin
            n_fail++;
            $display("FAIL b2b_idle: state %b need 000", state_out);
        end
        a_op = 8'hA5;
        b_op = 8'h3C;
        pulse_start();
        #1;
        n_checks++;
        if (state_out !== 3'b001 || count !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_count_restart: state %b count %b need 001 00", state_out, count);
        end
        wait_done(cyc);
        n_checks++;
        if (cyc !== 4 || prod !== 16'h26AC) begin
            n_fail++;
            $display("FAIL b2b_second: cycles %0d prod %h need 4 26ac", cyc, prod);
        end
        @(negedge clk);
    endtask

    task automatic test_illegal();
        @(negedge clk);
        start = 1'b0;
        force dut.state_reg = state_t'(3'b111);
        #1;
        n_checks++;
        if ({state_out, input_sel, shift_sel, clk_ena, sclr_n, done} !== 10'b111_00_00_0_1_0) begin
            n_fail++;
            $display("FAIL illegal_outputs: got %b need 1110000010",
                     {state_out, input_sel, shift_sel, clk_ena, sclr_n, done});
        end
        #1 release dut.state_reg;
        @(negedge clk);
        #1;
        n_checks++;
        if (state_out !== 3'b000 || clk_ena !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_recover: state %b ena %b need 000 0", state_out, clk_ena);
        end
    endtask

    task automatic test_async_reset();
        a_op = 8'h12;
        b_op = 8'h34;
        pulse_start();
        @(negedge clk);
        #1;
        n_checks++;
        if (state_out !== 3'b010 || count !== 2'b01) begin
            n_fail++;
            $display("FAIL async_setup_mid: state %b count %b need 010 01", state_out, count);
        end
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({state_out, count, clk_ena, sclr_n, done} !== 8'b000_00_0_1_0) begin
            n_fail++;
            $display("FAIL async_reset_mid: got %b need 00000010", {state_out, count, clk_ena, sclr_n, done});
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (state_out !== 3'b000 || count !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset_release: state %b count %b need 000 00", state_out, count);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_nominal();
        test_err_lsb();
        test_err_done();
        test_back_to_back();
        test_illegal();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
